// File: rtl/nav_pkg.sv
// Shared types and helpers for the navigator datapath: FSM states, int8 limits
// and the saturating requantiser used when a neuron's accumulator is written out.
package nav_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_MAC,
    ST_STORE,
    ST_ARGMAX,
    ST_DONE
  } state_t;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  // Callers sign-extend their ACC_W accumulator into the 64-bit argument.
  function automatic logic [7:0] sat_requant(input logic signed [63:0] acc, input int shift);
    logic signed [63:0] q;
    q = acc >>> shift;
    if (q > INT8_MAX) begin
      return 8'(INT8_MAX);
    end else if (q < INT8_MIN) begin
      return 8'(INT8_MIN);
    end
    return q[7:0];
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed 8x8 multiply with ACC_W accumulate; result visible the cycle after en.
// clr has priority over en; no flow control of its own.
module mac_unit #(
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [7:0]       a,
  input  logic signed [7:0]       b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [15:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(ACC_W-16){prod[15]}}, prod};
    end
  end

endmodule

// File: rtl/layer2_dense.sv
// Dense layer 2: latch activations, stream N_OUT*N_IN weights (valid/ready, one per cycle), requantise, argmax.
// Done 138 cycles after act_done with continuous weights; LAYER2_RELU_EN rectifies activations at latch time.
module layer2_dense
  import nav_pkg::*;
#(
  parameter int N_IN  = 32,
  parameter int N_OUT = 4,
  parameter int ACC_W = 24,
  parameter int SHIFT = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN*8-1:0]          act_in,
  input  logic                       act_done,
  input  logic [7:0]                 w,
  input  logic                       w_valid,
  output logic                       w_ready,
  output logic [N_OUT*8-1:0]         out_vec,
  output logic [$clog2(N_OUT)-1:0]   class_idx,
  output logic                       done
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW = $clog2(N_OUT);
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

  state_t state, state_nxt;

  logic [N_IN-1:0][7:0]     act_q;
  logic [IW-1:0]            i_cnt;
  logic [JW-1:0]            j_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic                     mac_en;
  logic                     mac_clr;
  logic signed [7:0]        best_val;
  logic [JW-1:0]            best_idx;
  logic signed [7:0]        cand;
  logic                     cand_wins;

  mac_unit #(.ACC_W(ACC_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (act_q[i_cnt]),
    .b   (w),
    .acc (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (act_done) state_nxt = ST_LATCH;
      ST_LATCH:  state_nxt = ST_MAC;
      ST_MAC:    if (w_valid && i_cnt == I_LAST) state_nxt = ST_STORE;
      ST_STORE:  state_nxt = (j_cnt == J_LAST) ? ST_ARGMAX : ST_MAC;
      ST_ARGMAX: if (j_cnt == J_LAST) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_DONE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready = (state == ST_MAC);
    done    = (state == ST_DONE);
    mac_en  = w_valid && (state == ST_MAC);
    mac_clr = (state == ST_LATCH) || (state == ST_STORE);
  end

  // The first scanned entry always seeds the running best; later ones need strictly greater.
  assign cand      = out_vec[j_cnt*8 +: 8];
  assign cand_wins = (j_cnt == '0) || (cand > best_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q     <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      out_vec   <= '0;
      class_idx <= '0;
      best_val  <= '0;
      best_idx  <= '0;
    end else begin
      case (state)
        ST_LATCH: begin
          for (int k = 0; k < N_IN; k++) begin
`ifdef LAYER2_RELU_EN
            act_q[k] <= act_in[k*8+7] ? 8'd0 : act_in[k*8 +: 8];
`else
            act_q[k] <= act_in[k*8 +: 8];
`endif
          end
          i_cnt <= '0;
          j_cnt <= '0;
        end
        ST_MAC: begin
          if (mac_en) begin
            i_cnt <= (i_cnt == I_LAST) ? '0 : i_cnt + 1'b1;
          end
        end
        ST_STORE: begin
          out_vec[j_cnt*8 +: 8] <= sat_requant({{(64-ACC_W){acc[ACC_W-1]}}, acc}, SHIFT);
          i_cnt <= '0;
          j_cnt <= (j_cnt == J_LAST) ? '0 : j_cnt + 1'b1;
        end
        ST_ARGMAX: begin
          if (cand_wins) begin
            best_val <= cand;
            best_idx <= j_cnt;
          end
          if (j_cnt == J_LAST) begin
            class_idx <= cand_wins ? j_cnt : best_idx;
            j_cnt     <= '0;
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
